imm_encoder: RTL and testbench
==============================

# imm_encoder

Iterative operand-2 encoder that runs in the opposite direction to the datapath's operand-2 value generation. Given a 32-bit constant, it searches for the 12-bit shifter-operand field (4-bit rotate plus 8-bit immediate) that regenerates that constant, and falls back to the bitwise-inverted constant (MVN form) when no direct encoding exists. In memory mode it instead checks whether the value fits a sign-extended 12-bit offset. It serves the instruction-assembly and self-test logic that builds instruction words for the core.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  request strobe; accepted only when busy_o=0.
- mem_i  in  1  sampled with start: 1 = memory-offset mode, 0 = data-processing immediate mode.
- value_i  in  32  constant to encode; sampled with start.
- busy_o  out  1  search in progress.
- done_o  out  1  one-cycle pulse when the result is valid.
- ok_o  out  1  encoding found; valid from done_o until the next accept.
- inv_o  out  1  encoding is of ~value_i (use MVN/BIC form).
- operand_o  out  12  encoded field: {rotate[3:0], immed_8[7:0]}, or offset[11:0] in memory mode.

## Operation
- States: IDLE, SRCH_POS, SRCH_INV.
- Accept: start_i=1 in IDLE.
  - Latch value and mode, and set rotate counter r=0.
  - Go to SRCH_POS, or in memory mode resolve at the next edge.
- Match test for rotation r on candidate c: rol(c, 2r)[31:8]==0.
  - Encoding = {r, rol(c, 2r)[7:0]}.
  - This is exactly the inverse of ROR-by-2r of a zero-extended byte.
- Each SRCH cycle tests one r, ascending 0..15; the first match wins (smallest rotate).
- SRCH_POS:
  - On match: ok=1, inv=0, done pulse, return to IDLE.
  - At r=15 with no match: go to SRCH_INV with r=0 and candidate = ~value.
- SRCH_INV:
  - On match: ok=1, inv=1, done pulse, return to IDLE.
  - At r=15 with no match: ok=0, inv=0, operand=0, done pulse, return to IDLE.
- Memory mode is a single check:
  - If value[31:11] is all 0s or all 1s: ok=1, operand=value[11:0].
  - Otherwise: ok=0, operand=0.
  - inv is always 0.
- Result registers (ok_o, inv_o, operand_o) hold from done_o until the next accepted start. They are cleared at accept.
- start_i while busy_o=1 is ignored; it is neither queued nor allowed to corrupt the search.
- rst mid-search aborts immediately. No done_o pulse is produced for the aborted request.

## Timing
- Reset values: busy_o=0, done_o=0, ok_o=0, inv_o=0, operand_o=0, state IDLE, r=0.
- Let edge 0 be the accept edge. busy_o=1 from edge 0 until the done edge.
- Latency in data-processing mode:
  - Direct match at rotate k: done_o rises at edge k+1.
  - Inverted match at rotate k: done_o rises at edge 17+k.
  - Total failure: done_o rises at edge 32.
- Latency in memory mode: done_o rises at edge 1.
- All outputs are registered. done_o is high for exactly one cycle.
- busy_o falls at the same edge that done_o rises.
- start_i asserted during the done_o cycle is accepted at the next edge, so back-to-back requests incur no bubble.

## Test plan
- Direct, rotate 0: value 0x000000FF, mem=0 -> done at edge 1, ok=1, inv=0, operand=0x0FF.
- Direct, rotate 4: value 0xFF000000 -> done at edge 5, ok=1, inv=0, operand=0x4FF.
- Direct, rotate 15: value 0x00000104 -> done at edge 16, operand=0xF41.
- Inverted fallback and failure:
  - value 0xFFFFFF00 -> done at edge 17, ok=1, inv=1, operand=0x0FF.
  - value 0x12345678 -> done at edge 32, ok=0, inv=0, operand=0.
- Memory mode:
  - 0xFFFFF800 -> done at edge 1, ok=1, operand=0x800.
  - 0x000007FF -> ok=1, operand=0x7FF.
  - 0x00000800 -> ok=0, operand=0.
- Control:
  - start during busy is ignored and the result matches the first request.
  - rst asserted at edge 5 of a 0x12345678 search -> all outputs 0, no done pulse, and a new start afterwards encodes correctly.

Source files
------------

// File: rtl/imm_encoder.sv
// Iterative operand-2 encoder: finds {rotate, imm8} regenerating a 32-bit constant,
// falling back to the inverted constant, or checks a signed 12-bit memory offset.
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        mem_i,
  input  logic [31:0] value_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        ok_o,
  output logic        inv_o,
  output logic [11:0] operand_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ROT_W  = 4;
  localparam int unsigned OP_W   = 12;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SRCH_POS = 2'd1;
  localparam logic [1:0] ST_SRCH_INV = 2'd2;

  localparam logic [ROT_W-1:0] ROT_LAST = 4'd15;

  logic [1:0]        r_state;
  logic [ROT_W-1:0]  r_rot;
  logic [DATA_W-1:0] r_cand;
  logic              r_mem;
  logic              r_busy;
  logic              r_done;
  logic              r_ok;
  logic              r_inv;
  logic [OP_W-1:0]   r_operand;

  logic [1:0]        w_state_nxt;
  logic [ROT_W-1:0]  w_rot_nxt;
  logic [DATA_W-1:0] w_cand_nxt;
  logic              w_mem_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_ok_nxt;
  logic              w_inv_nxt;
  logic [OP_W-1:0]   w_operand_nxt;

  logic [4:0]        w_sh;
  logic [DATA_W-1:0] w_rol;
  logic              w_match;
  logic              w_mem_fit;
  logic [OP_W-1:0]   w_enc;

  // Rotate the candidate left by 2r; a match means it is a zero-extended byte.
  assign w_sh      = 5'({r_rot, 1'b0});
  assign w_rol     = (r_cand << w_sh) | (r_cand >> (6'd32 - 6'(w_sh)));
  assign w_match   = (w_rol[31:8] == 24'd0);
  assign w_enc     = {r_rot, w_rol[7:0]};
  assign w_mem_fit = (r_cand[31:11] == 21'h000000) || (r_cand[31:11] == 21'h1FFFFF);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_rot_nxt     = r_rot;
    w_cand_nxt    = r_cand;
    w_mem_nxt     = r_mem;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_ok_nxt      = r_ok;
    w_inv_nxt     = r_inv;
    w_operand_nxt = r_operand;

    case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start_i) begin
          w_state_nxt   = ST_SRCH_POS;
          w_rot_nxt     = '0;
          w_cand_nxt    = value_i;
          w_mem_nxt     = mem_i;
          w_busy_nxt    = 1'b1;
          w_ok_nxt      = 1'b0;
          w_inv_nxt     = 1'b0;
          w_operand_nxt = '0;
        end
      end

      ST_SRCH_POS: begin
        if (r_mem) begin
          w_state_nxt   = ST_IDLE;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_ok_nxt      = w_mem_fit;
          w_inv_nxt     = 1'b0;
          w_operand_nxt = w_mem_fit ? r_cand[11:0] : 12'd0;
        end else if (w_match) begin
          w_state_nxt   = ST_IDLE;
          w_rot_nxt     = '0;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_ok_nxt      = 1'b1;
          w_inv_nxt     = 1'b0;
          w_operand_nxt = w_enc;
        end else if (r_rot == ROT_LAST) begin
          w_state_nxt = ST_SRCH_INV;
          w_rot_nxt   = '0;
          w_cand_nxt  = ~r_cand;
        end else begin
          w_rot_nxt = ROT_W'(r_rot + 4'd1);
        end
      end

      ST_SRCH_INV: begin
        if (w_match) begin
          w_state_nxt   = ST_IDLE;
          w_rot_nxt     = '0;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_ok_nxt      = 1'b1;
          w_inv_nxt     = 1'b1;
          w_operand_nxt = w_enc;
        end else if (r_rot == ROT_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_rot_nxt     = '0;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_ok_nxt      = 1'b0;
          w_inv_nxt     = 1'b0;
          w_operand_nxt = '0;
        end else begin
          w_rot_nxt = ROT_W'(r_rot + 4'd1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_rot_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rot     <= '0;
      r_cand    <= '0;
      r_mem     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_inv     <= 1'b0;
      r_operand <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rot     <= w_rot_nxt;
      r_cand    <= w_cand_nxt;
      r_mem     <= w_mem_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_ok      <= w_ok_nxt;
      r_inv     <= w_inv_nxt;
      r_operand <= w_operand_nxt;
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign ok_o      = r_ok;
  assign inv_o     = r_inv;
  assign operand_o = r_operand;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: vector table plus control corner cases, results checked
// through a scoreboard queue popped on each done pulse.
module tb_imm_encoder;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        mem_i;
  logic [31:0] value_i;
  logic        busy_o;
  logic        done_o;
  logic        ok_o;
  logic        inv_o;
  logic [11:0] operand_o;

  imm_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .mem_i     (mem_i),
    .value_i   (value_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .ok_o      (ok_o),
    .inv_o     (inv_o),
    .operand_o (operand_o)
  );

  typedef struct {
    logic        mem;
    logic [31:0] value;
    logic        ok;
    logic        inv;
    logic [11:0] op;
    int          lat;
  } vec_t;

  typedef struct {
    logic        ok;
    logic        inv;
    logic [11:0] op;
    int          acc;
    int          lat;
    logic [31:0] value;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];
  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop the scoreboard on each done pulse.
  always @(posedge clk) begin
    #1;
    if (done_o === 1'b1) begin
      chk("done_single_cycle", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with no request pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ok",      32'(ok_o),      32'(e.ok));
        chk("inv",     32'(inv_o),     32'(e.inv));
        chk("operand", 32'(operand_o), 32'(e.op));
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("busy_at_done", 32'(busy_o), 32'd0);
      end
    end
    prev_done = done_o;
  end

  task automatic issue(input logic mem, input logic [31:0] value, input logic ok,
                       input logic inv, input logic [11:0] op, input int lat);
    exp_t e;
    @(negedge clk);
    start_i = 1'b1;
    mem_i   = mem;
    value_i = value;
    @(posedge clk);
    #1;
    e.ok = ok; e.inv = inv; e.op = op; e.acc = cyc; e.lat = lat; e.value = value;
    sb.push_back(e);
    chk("busy_after_accept", 32'(busy_o), 32'd1);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d results still pending after %0d cycles", sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_o !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL timeout_done: no done within %0d cycles", budget);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    mem_i   = 1'b0;
    value_i = 32'd0;

    vecs.push_back('{1'b0, 32'h000000FF, 1'b1, 1'b0, 12'h0FF, 1});
    vecs.push_back('{1'b0, 32'hFF000000, 1'b1, 1'b0, 12'h4FF, 5});
    vecs.push_back('{1'b0, 32'h00000104, 1'b1, 1'b0, 12'hF41, 16});
    vecs.push_back('{1'b0, 32'hFFFFFF00, 1'b1, 1'b1, 12'h0FF, 17});
    vecs.push_back('{1'b0, 32'h12345678, 1'b0, 1'b0, 12'h000, 32});
    vecs.push_back('{1'b0, 32'h00000000, 1'b1, 1'b0, 12'h000, 1});
    vecs.push_back('{1'b0, 32'h000003FC, 1'b1, 1'b0, 12'hFFF, 16});
    vecs.push_back('{1'b0, 32'hF000000F, 1'b1, 1'b0, 12'h2FF, 3});
    vecs.push_back('{1'b0, 32'hFFFFFEFB, 1'b1, 1'b1, 12'hF41, 32});
    vecs.push_back('{1'b1, 32'hFFFFF800, 1'b1, 1'b0, 12'h800, 1});
    vecs.push_back('{1'b1, 32'h000007FF, 1'b1, 1'b0, 12'h7FF, 1});
    vecs.push_back('{1'b1, 32'h00000800, 1'b0, 1'b0, 12'h000, 1});
    vecs.push_back('{1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 12'hFFF, 1});
    vecs.push_back('{1'b1, 32'h12345678, 1'b0, 1'b0, 12'h000, 1});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",    32'(busy_o),    32'd0);
    chk("rst_done",    32'(done_o),    32'd0);
    chk("rst_ok",      32'(ok_o),      32'd0);
    chk("rst_inv",     32'(inv_o),     32'd0);
    chk("rst_operand", 32'(operand_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].mem, vecs[i].value, vecs[i].ok, vecs[i].inv, vecs[i].op, vecs[i].lat);
      wait_idle(40);
    end

    // Start strobes during busy must be ignored; result then holds while idle.
    issue(1'b0, 32'hFFFFFF00, 1'b1, 1'b1, 12'h0FF, 17);
    repeat (3) begin
      @(negedge clk);
      start_i = 1'b1;
      mem_i   = 1'b1;
      value_i = 32'h00000800;
    end
    @(negedge clk);
    start_i = 1'b0;
    wait_idle(40);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_ok",      32'(ok_o),      32'd1);
    chk("hold_inv",     32'(inv_o),     32'd1);
    chk("hold_operand", 32'(operand_o), 32'h0FF);
    chk("hold_busy",    32'(busy_o),    32'd0);

    // Back-to-back: second start raised during the first done cycle.
    issue(1'b0, 32'hFF000000, 1'b1, 1'b0, 12'h4FF, 5);
    wait_done(40);
    issue(1'b1, 32'h000007FF, 1'b1, 1'b0, 12'h7FF, 1);
    wait_done(10);
    issue(1'b0, 32'h00000104, 1'b1, 1'b0, 12'hF41, 16);
    wait_idle(40);

    // Reset at edge 5 of a failing search aborts with no done pulse.
    issue(1'b0, 32'h12345678, 1'b0, 1'b0, 12'h000, 32);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("abort_busy",    32'(busy_o),    32'd0);
    chk("abort_done",    32'(done_o),    32'd0);
    chk("abort_ok",      32'(ok_o),      32'd0);
    chk("abort_inv",     32'(inv_o),     32'd0);
    chk("abort_operand", 32'(operand_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    issue(1'b0, 32'hFF000000, 1'b1, 1'b0, 12'h4FF, 5);
    wait_idle(40);
    repeat (3) @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
